// File: rtl/pump_pair_scheduler.sv
// Purpose: runs none, one or both of a pump pair from high/low level sensors, alternating lead pump per fill cycle.
// Latency: one cycle; every output is registered and reflects the inputs sampled at the previous rising Clock edge.
// Backpressure: none; sensors and faults are sampled every cycle and the block never stalls.
//
// Ports:
//   Clock         system clock, rising edge
//   R             synchronous active-high reset; dominates everything, no minimum run honoured
//   S, I          high-level / low-level sensors (1 = water at or above that sensor)
//   F1, F2        pump faults (1 = pump unavailable, never driven)
//   B1, B2        pump drives
//   Lead          pump to start next (0 = pump 1, 1 = pump 2)
//   Alarm         sensor inconsistency, or demand with no healthy pump
module pump_pair_scheduler #(
    parameter int MIN_ON      = 8,
    parameter int START_DELAY = 2,
    parameter int CNT_W       = 8
) (
    input  logic Clock,
    input  logic R,
    input  logic S,
    input  logic I,
    input  logic F1,
    input  logic F2,
    output logic B1,
    output logic B2,
    output logic Lead,
    output logic Alarm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] START_C  = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state, state_nx;
    logic             active, active_nx;   // 0 = pump 1 leads the current run
    logic             lead_nx, alarm_nx, b1_nx, b2_nx;
    logic [CNT_W-1:0] min_cnt, min_nx;
    logic [CNT_W-1:0] stag_cnt, stag_nx;

    // Demand decode: S=0 means at least one pump wanted, S=0 & I=0 means both.
    logic sens_err, dem_any, dem_two;
    assign sens_err = S & ~I;
    assign dem_any  = ~S;
    assign dem_two  = ~S & ~I;

    logic act_ok, oth_ok, lead_ok, lead_oth_ok;
    assign act_ok      = active ? ~F2 : ~F1;
    assign oth_ok      = active ? ~F1 : ~F2;
    assign lead_ok     = Lead   ? ~F2 : ~F1;
    assign lead_oth_ok = Lead   ? ~F1 : ~F2;

    // min_inc counts the cycle being closed by this edge, so a pump started at
    // edge t sees min_done first at edge t+MIN_ON. Saturates at MIN_ON.
    logic [CNT_W-1:0] min_inc, stag_inc;
    logic             min_done;
    assign min_inc  = (min_cnt >= MIN_ON_C) ? MIN_ON_C : (min_cnt + ONE_C);
    assign min_done = (min_inc >= MIN_ON_C);
    assign stag_inc = stag_cnt + ONE_C;

    always_comb begin
        state_nx  = state;
        active_nx = active;
        lead_nx   = Lead;
        min_nx    = min_cnt;
        stag_nx   = stag_cnt;

        if (sens_err) begin
            // Sensor inconsistency overrides faults, demand and min-on.
            state_nx = ERR;
            min_nx   = '0;
            stag_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    min_nx  = '0;
                    stag_nx = '0;
                    if (dem_any) begin
                        if (lead_ok) begin
                            state_nx  = RUN1;
                            active_nx = Lead;
                        end else if (lead_oth_ok) begin
                            state_nx  = RUN1;
                            active_nx = ~Lead;
                        end
                    end
                end

                RUN1: begin
                    if (!act_ok) begin
                        stag_nx = '0;
                        min_nx  = '0;
                        if (oth_ok) begin
                            // Failover: the survivor is treated as freshly started.
                            active_nx = ~active;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        min_nx = min_inc;
                        if (dem_two && oth_ok) begin
                            stag_nx = stag_inc;
                            if (stag_inc >= START_C) begin
                                state_nx = RUN2;
                                stag_nx  = '0;
                            end
                        end else begin
                            stag_nx = '0;
                            if (!dem_any && min_done) begin
                                state_nx = IDLE;
                                lead_nx  = ~active;
                                min_nx   = '0;
                            end
                        end
                    end
                end

                RUN2: begin
                    stag_nx = '0;
                    if (F1 && F2) begin
                        state_nx = IDLE;
                        min_nx   = '0;
                    end else if (!act_ok) begin
                        state_nx  = RUN1;
                        active_nx = ~active;
                        min_nx    = '0;
                    end else begin
                        // Lag fault or demand drop: lead keeps running on its original timer.
                        min_nx = min_inc;
                        if (!oth_ok || !dem_two) begin
                            state_nx = RUN1;
                        end
                    end
                end

                ERR: begin
                    min_nx   = '0;
                    stag_nx  = '0;
                    state_nx = IDLE;
                end

                default: begin
                    state_nx = IDLE;
                    min_nx   = '0;
                    stag_nx  = '0;
                end
            endcase
        end

        alarm_nx = (state_nx == ERR) | (dem_any & F1 & F2);
        b1_nx    = ((state_nx == RUN2) | ((state_nx == RUN1) & ~active_nx)) & ~F1;
        b2_nx    = ((state_nx == RUN2) | ((state_nx == RUN1) &  active_nx)) & ~F2;
    end

    always_ff @(posedge Clock) begin
        if (R) begin
            state    <= IDLE;
            active   <= 1'b0;
            Lead     <= 1'b0;
            Alarm    <= 1'b0;
            B1       <= 1'b0;
            B2       <= 1'b0;
            min_cnt  <= '0;
            stag_cnt <= '0;
        end else begin
            state    <= state_nx;
            active   <= active_nx;
            Lead     <= lead_nx;
            Alarm    <= alarm_nx;
            B1       <= b1_nx;
            B2       <= b2_nx;
            min_cnt  <= min_nx;
            stag_cnt <= stag_nx;
        end
    end

endmodule

// File: tb/tb_pump_pair_scheduler.sv
module tb_pump_pair_scheduler;

    logic Clock = 1'b0;
    logic R, S, I, F1, F2;
    logic B1, B2, Lead, Alarm;

    pump_pair_scheduler #(
        .MIN_ON     (8),
        .START_DELAY(2),
        .CNT_W      (8)
    ) dut (
        .Clock(Clock),
        .R    (R),
        .S    (S),
        .I    (I),
        .F1   (F1),
        .F2   (F2),
        .B1   (B1),
        .B2   (B2),
        .Lead (Lead),
        .Alarm(Alarm)
    );

    always #5 Clock = ~Clock;

    // exp packs {B1, B2, Lead, Alarm} as seen right after the sampling edge.
    typedef struct packed {
        logic       r;
        logic       s;
        logic       i;
        logic       f1;
        logic       f2;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic void add(input logic r, input logic s, input logic i,
                                input logic f1, input logic f2,
                                input logic [3:0] e, input int rep = 1);
        vec_t v;
        v.r = r; v.s = s; v.i = i; v.f1 = f1; v.f2 = f2; v.exp = e;
        for (int k = 0; k < rep; k++) vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v, input string name);
        logic [3:0] got;
        logic [3:0] want;
        R  = v.r;
        S  = v.s;
        I  = v.i;
        F1 = v.f1;
        F2 = v.f2;
        sb.push_back(v.exp);
        @(posedge Clock);
        #1;
        got  = {B1, B2, Lead, Alarm};
        want = sb.pop_front();
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: {B1,B2,Lead,Alarm} got %b want %b", name, got, want);
    endtask

    task automatic step(input logic r, input logic s, input logic i,
                        input logic f1, input logic f2,
                        input logic [3:0] e, input string name);
        vec_t v;
        v.r = r; v.s = s; v.i = i; v.f1 = f1; v.f2 = f2; v.exp = e;
        drive(v, name);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        R = 1'b1; S = 1'b1; I = 1'b1; F1 = 1'b0; F2 = 1'b0;

        // Reset, full tank
        add(1, 1, 1, 0, 0, 4'b0000, 2);
        // Fill cycle 1 on pump 1: demand for 2 edges then satisfied; off at edge 8, Lead flips
        add(0, 0, 1, 0, 0, 4'b1000, 2);
        add(0, 1, 1, 0, 0, 4'b1000, 6);
        add(0, 1, 1, 0, 0, 4'b0010, 2);
        // Fill cycle 2 alternates to pump 2; Lead returns to 0
        add(0, 0, 1, 0, 0, 4'b0110);
        add(0, 1, 1, 0, 0, 4'b0110, 7);
        add(0, 1, 1, 0, 0, 4'b0000);
        // High demand: lag joins at edge 2, drops at edge 5, lead off at edge 8
        add(0, 0, 0, 0, 0, 4'b1000, 2);
        add(0, 0, 0, 0, 0, 4'b1100, 3);
        add(0, 0, 1, 0, 0, 4'b1000);
        add(0, 1, 1, 0, 0, 4'b1000, 2);
        add(0, 1, 1, 0, 0, 4'b0010);
        // Sensor error in RUN2 with Lead=1: all off, Alarm; recovery keeps Lead
        add(0, 0, 0, 0, 0, 4'b0110, 2);
        add(0, 0, 0, 0, 0, 4'b1110);
        add(0, 1, 0, 0, 0, 4'b0011, 2);
        add(0, 1, 1, 0, 0, 4'b0010);

        for (int k = 0; k < vecs.size(); k++)
            drive(vecs[k], $sformatf("vec%0d", k));

        // Reset pulsed mid-RUN2 at the third cycle of the run
        step(0, 0, 0, 0, 0, 4'b0110, "g_lead");
        step(0, 0, 0, 0, 0, 4'b0110, "g_stagger");
        step(0, 0, 0, 0, 0, 4'b1110, "g_run2");
        step(1, 0, 0, 0, 0, 4'b0000, "g_reset");
        step(0, 0, 1, 0, 0, 4'b1000, "g_restart");
        for (int k = 0; k < 7; k++)
            step(0, 1, 1, 0, 0, 4'b1000, $sformatf("g_minon%0d", k));
        step(0, 1, 1, 0, 0, 4'b0010, "g_stop");

        // Pump 2 cycle to bring Lead back to 0
        step(0, 0, 1, 0, 0, 4'b0110, "p_b2");
        for (int k = 0; k < 7; k++)
            step(0, 1, 1, 0, 0, 4'b0110, $sformatf("p_minon%0d", k));
        step(0, 1, 1, 0, 0, 4'b0000, "p_stop");

        // Failover from pump 1 to pump 2; min timer restarts on the survivor
        step(0, 0, 1, 0, 0, 4'b1000, "e_b1");
        step(0, 0, 1, 0, 0, 4'b1000, "e_b1_hold");
        step(0, 0, 1, 1, 0, 4'b0100, "e_failover");
        for (int k = 0; k < 7; k++)
            step(0, 1, 1, 1, 0, 4'b0100, $sformatf("e_minon%0d", k));
        step(0, 1, 1, 1, 0, 4'b0000, "e_stop");

        // Faulted lead skipped, then both faulted under demand
        step(0, 0, 1, 1, 0, 4'b0100, "e_skip_lead");
        step(0, 0, 1, 1, 1, 4'b0001, "e_both_fault");
        step(0, 0, 1, 1, 1, 4'b0001, "e_alarm_hold");
        step(0, 1, 1, 1, 1, 4'b0000, "e_alarm_clr");
        step(0, 1, 1, 0, 0, 4'b0000, "e_faults_clr");

        // Lag fault in RUN2: lag stops, lead keeps its original min timer
        step(0, 0, 0, 0, 0, 4'b1000, "l_lead");
        step(0, 0, 0, 0, 0, 4'b1000, "l_stagger");
        step(0, 0, 0, 0, 0, 4'b1100, "l_run2");
        step(0, 0, 0, 0, 1, 4'b1000, "l_lagfault");
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 0, 1, 4'b1000, $sformatf("l_minon%0d", k));
        step(0, 1, 1, 0, 1, 4'b0010, "l_stop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
